// File: rtl/scpu_dump_pkg.sv
// Shared types and frame constants for the CPU state-dump UART serializer.
// Defining SCPU_DUMP_SYNC_EN prefixes every frame with the SYNC_BYTE marker.
package scpu_dump_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_e;

  // {r1, r2, r3}, r1 in the top word.
  typedef logic [95:0] snapshot_t;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

`ifdef SCPU_DUMP_SYNC_EN
  localparam bit SYNC_EN     = 1'b1;
  localparam int FRAME_BYTES = 13;
`else
  localparam bit SYNC_EN     = 1'b0;
  localparam int FRAME_BYTES = 12;
`endif

endpackage

// File: rtl/scpu_dump_fifo.sv
// Synchronous snapshot FIFO; a push into a full FIFO is still accepted when a
// pop happens in the same cycle, because the popped slot is the one written.
module scpu_dump_fifo
  import scpu_dump_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      push_i,
  input  logic      pop_i,
  input  snapshot_t wdata_i,
  output snapshot_t rdata_o,
  output logic      full_o,
  output logic      empty_o
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  snapshot_t   mem_q [DEPTH];
  logic [AW:0] wr_q, rd_q;
  logic        do_push, do_pop;

  // Extra pointer MSB tells a full FIFO apart from an empty one.
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign rdata_o = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + PTR_ONE;
      if (do_pop)  rd_q <= rd_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/scpu_dump_tx.sv
// CPU state-dump serializer: snapshots r1..r3 on dump edges, sends 8N1 frames.
// Build option SCPU_DUMP_SYNC_EN adds a leading 0xA5 sync byte to each frame.
//
//   state | meaning
//   IDLE  | waiting for a queued snapshot
//   LOAD  | pop head snapshot into the shift register, byte index 0
//   START | start bit (line low) for one bit time
//   DATA  | 8 data bits, LSB first
//   STOP  | stop bit (line high); next byte or back to IDLE
module scpu_dump_tx
  import scpu_dump_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dump_i,
  input  logic        halt_i,
  input  logic [31:0] r1_i,
  input  logic [31:0] r2_i,
  input  logic [31:0] r3_i,
  output logic        tx_o,
  output logic        busy_o,
  output logic        overflow_o,
  output logic        done_o
);

  localparam int            TW       = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] T_LAST   = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] T_ONE    = TW'(1);
  localparam logic [3:0]    LAST_IDX = 4'(FRAME_BYTES - 1);

  state_e        state_q, state_d;
  logic          dump_q, halted_q, overflow_q, busy_q;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    bit_q, bit_d;
  logic [3:0]    idx_q, idx_d;
  snapshot_t     shreg_q, shreg_d;
  snapshot_t     fifo_rdata;
  logic          req, pop, fifo_full, fifo_empty, tick, tx_bit;
  logic [7:0]    cur_byte;

  // Requests that arrive once the CPU has halted are ignored.
  assign req      = dump_i & ~dump_q & ~halted_q;
  assign pop      = (state_q == ST_LOAD);
  assign tick     = (timer_q == T_LAST);
  assign cur_byte = (SYNC_EN && idx_q == 4'd0) ? SYNC_BYTE : shreg_q[95:88];

  scpu_dump_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push_i (req),
    .pop_i  (pop),
    .wdata_i({r1_i, r2_i, r3_i}),
    .rdata_o(fifo_rdata),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    bit_d   = bit_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    tx_bit  = 1'b1;
    if (state_q inside {ST_START, ST_DATA, ST_STOP}) begin
      timer_d = tick ? '0 : timer_q + T_ONE;
    end
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        shreg_d = fifo_rdata;
        idx_d   = 4'd0;
        bit_d   = 3'd0;
        timer_d = '0;
        state_d = ST_START;
      end
      ST_START: begin
        tx_bit = 1'b0;
        if (tick) state_d = ST_DATA;
      end
      ST_DATA: begin
        tx_bit = cur_byte[bit_q];
        if (tick) begin
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_IDLE;
          end else begin
            idx_d   = idx_q + 4'd1;
            // The sync byte is not held in the shift register.
            if (!(SYNC_EN && idx_q == 4'd0)) shreg_d = shreg_q << 8;
            state_d = ST_START;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      dump_q     <= 1'b0;
      halted_q   <= 1'b0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
      timer_q    <= '0;
      bit_q      <= 3'd0;
      idx_q      <= 4'd0;
      shreg_q    <= '0;
    end else begin
      state_q    <= state_d;
      dump_q     <= dump_i;
      halted_q   <= halted_q | halt_i;
      overflow_q <= overflow_q | (req & fifo_full & ~pop);
      busy_q     <= (state_q != ST_IDLE) | ~fifo_empty;
      timer_q    <= timer_d;
      bit_q      <= bit_d;
      idx_q      <= idx_d;
      shreg_q    <= shreg_d;
    end
  end

  assign tx_o       = tx_bit;
  assign busy_o     = busy_q;
  assign overflow_o = overflow_q;
  assign done_o     = halted_q & fifo_empty & (state_q == ST_IDLE);

endmodule
